// File: rtl/color_bounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : color_bounce_pkg
// Description : Shared types and constants for the colour-bounce frame
//               drawing path. Contains the sequencer state enum, the screen
//               geometry, the game-state field widths and helpers that slice
//               one platform's position or colour out of the packed fields.
// Revision    : 1.0 - initial release
// ============================================================================
package color_bounce_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ERASE = 3'd2,
        S_BALL  = 3'd3,
        S_PLAT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;

    localparam int BALL_W    = 8;   // {col[3:0], row[3:0]}
    localparam int POS_W     = 7;   // platform top-row y
    localparam int COL_W     = 3;   // pixel colour
    localparam int NUM_PLATS = 4;

    // Scanner counter widths: px covers widths up to 63, py heights up to 8.
    localparam int SCAN_XW   = 6;
    localparam int SCAN_YW   = 3;

    function automatic logic [POS_W-1:0] plat_pos(
        input logic [NUM_PLATS*POS_W-1:0] v,
        input logic [1:0]                 i
    );
        return v[POS_W*i +: POS_W];
    endfunction

    function automatic logic [COL_W-1:0] plat_col(
        input logic [NUM_PLATS*COL_W-1:0] v,
        input logic [1:0]                 i
    );
        return v[COL_W*i +: COL_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_scanner.sv
`default_nettype none
// ============================================================================
// Module      : rect_scanner
// Description : Row-major rectangle scan counter. load restarts at (0,0);
//               advance steps px, wrapping into py at the end of each row.
//               last flags the final cell of the w x h rectangle.
// Ports       : clk, reset (async active-low), load, advance, w, h -> px, py,
//               last
// Revision    : 1.0 - initial release
// ============================================================================
module rect_scanner
    import color_bounce_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic [SCAN_XW:0]   w,
    input  logic [SCAN_YW:0]   h,
    output logic [SCAN_XW-1:0] px,
    output logic [SCAN_YW-1:0] py,
    output logic               last
);

    logic [SCAN_XW-1:0] px_q;
    logic [SCAN_YW-1:0] py_q;
    logic               row_end;

    assign row_end = ({1'b0, px_q} == (w - {{SCAN_XW{1'b0}}, 1'b1}));
    assign last    = row_end && ({1'b0, py_q} == (h - {{SCAN_YW{1'b0}}, 1'b1}));
    assign px      = px_q;
    assign py      = py_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_q <= '0;
            py_q <= '0;
        end else if (load) begin
            px_q <= '0;
            py_q <= '0;
        end else if (advance) begin
            if (row_end) begin
                px_q <= '0;
                py_q <= py_q + {{(SCAN_YW-1){1'b0}}, 1'b1};
            end else begin
                px_q <= px_q + {{(SCAN_XW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_draw_sequencer
// Description : Converts one snapshot of the game state into a stream of
//               single-pixel writes: erase previous ball (skipped when the
//               ball did not move), draw current ball, draw four platforms.
//               Pixels use a plot/plot_ready handshake; off-screen pixels are
//               dropped without waiting for the adapter.
// Ports       : clk, reset (async active-low), start, prev_ball_in,
//               curr_ball_in, color_ball_in, color_plats_in,
//               position_plats_in, plot_ready -> busy, done, plot, x, y,
//               colour
// Revision    : 1.0 - initial release
// ============================================================================
module frame_draw_sequencer
    import color_bounce_pkg::*;
#(
    parameter int         BALL_SZ    = 8,
    parameter int         PLAT_W     = 32,
    parameter int         PLAT_H     = 2,
    parameter int         PLAT_PITCH = 40,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BALL_W-1:0]          prev_ball_in,
    input  logic [BALL_W-1:0]          curr_ball_in,
    input  logic [COL_W-1:0]           color_ball_in,
    input  logic [NUM_PLATS*COL_W-1:0] color_plats_in,
    input  logic [NUM_PLATS*POS_W-1:0] position_plats_in,
    input  logic                       plot_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       plot,
    output logic [7:0]                 x,
    output logic [6:0]                 y,
    output logic [2:0]                 colour
);

    state_t                     state_q;
    logic                       busy_q, done_q, plot_q, fin_q;
    logic [7:0]                 x_q;
    logic [6:0]                 y_q;
    logic [2:0]                 colour_q;
    logic [1:0]                 plat_q;
    logic [BALL_W-1:0]          prev_q, curr_q;
    logic [COL_W-1:0]           col_ball_q;
    logic [NUM_PLATS*COL_W-1:0] col_plats_q;
    logic [NUM_PLATS*POS_W-1:0] pos_plats_q;

    logic [SCAN_XW-1:0] px;
    logic [SCAN_YW-1:0] py;
    logic               scan_last;
    logic [SCAN_XW:0]   shape_w_d;
    logic [SCAN_YW:0]   shape_h_d;
    logic               scan_load_d, scan_adv_d;

    // Slot coordinates are one bit wider than the outputs so clipping sees
    // the true value before truncation.
    logic [8:0] sx_d;
    logic [7:0] sy_d;
    logic [2:0] scol_d;
    logic       clip_d, in_shape_d, issue_d, drain_d, last_plat_d;

    rect_scanner u_scan (
        .clk     (clk),
        .reset   (reset),
        .load    (scan_load_d),
        .advance (scan_adv_d),
        .w       (shape_w_d),
        .h       (shape_h_d),
        .px      (px),
        .py      (py),
        .last    (scan_last)
    );

    always_comb begin
        shape_w_d = (SCAN_XW+1)'(BALL_SZ);
        shape_h_d = (SCAN_YW+1)'(BALL_SZ);
        sx_d      = 9'(curr_q[7:4]) * 9'(BALL_SZ) + 9'(px);
        sy_d      = 8'(curr_q[3:0]) * 8'(BALL_SZ) + 8'(py);
        scol_d    = col_ball_q;
        if (state_q == S_ERASE) begin
            sx_d   = 9'(prev_q[7:4]) * 9'(BALL_SZ) + 9'(px);
            sy_d   = 8'(prev_q[3:0]) * 8'(BALL_SZ) + 8'(py);
            scol_d = BG_COLOUR;
        end else if (state_q == S_PLAT) begin
            shape_w_d = (SCAN_XW+1)'(PLAT_W);
            shape_h_d = (SCAN_YW+1)'(PLAT_H);
            sx_d      = 9'(plat_q) * 9'(PLAT_PITCH) + 9'(px);
            sy_d      = 8'(plat_pos(pos_plats_q, plat_q)) + 8'(py);
            scol_d    = plat_col(col_plats_q, plat_q);
        end
        clip_d      = (sx_d > 9'(SCREEN_W-1)) || (sy_d > 8'(SCREEN_H-1));
        in_shape_d  = (state_q == S_ERASE) || (state_q == S_BALL) || (state_q == S_PLAT);
        // A new slot may replace the output register when nothing is being
        // presented or the presented pixel is accepted this edge.
        issue_d     = in_shape_d && !fin_q && (!plot_q || plot_ready);
        drain_d     = in_shape_d &&  fin_q && (!plot_q || plot_ready);
        last_plat_d = (plat_q == 2'(NUM_PLATS-1));
        scan_load_d = (state_q == S_LOAD) ||
                      (issue_d && scan_last && !((state_q == S_PLAT) && last_plat_d));
        scan_adv_d  = issue_d && !scan_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            plot_q      <= 1'b0;
            fin_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plat_q      <= '0;
            prev_q      <= '0;
            curr_q      <= '0;
            col_ball_q  <= '0;
            col_plats_q <= '0;
            pos_plats_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    prev_q      <= prev_ball_in;
                    curr_q      <= curr_ball_in;
                    col_ball_q  <= color_ball_in;
                    col_plats_q <= color_plats_in;
                    pos_plats_q <= position_plats_in;
                    plat_q      <= '0;
                    fin_q       <= 1'b0;
                    state_q     <= (prev_ball_in != curr_ball_in) ? S_ERASE : S_BALL;
                end
                S_ERASE, S_BALL, S_PLAT: begin
                    if (drain_d) begin
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (issue_d) begin
                        plot_q   <= !clip_d;
                        x_q      <= sx_d[7:0];
                        y_q      <= sy_d[6:0];
                        colour_q <= scol_d;
                        if (scan_last) begin
                            if (state_q == S_ERASE) begin
                                state_q <= S_BALL;
                            end else if (state_q == S_BALL) begin
                                state_q <= S_PLAT;
                                plat_q  <= '0;
                            end else if (last_plat_d) begin
                                // Last slot issued; wait for its acceptance.
                                fin_q <= 1'b1;
                            end else begin
                                plat_q <= plat_q + 2'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_draw_sequencer
// Description : Self-checking bench for frame_draw_sequencer. A reference
//               model pushes the expected accepted-pixel sequence into a
//               queue before each frame; accepted pixels are collected from
//               the DUT and compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_draw_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  prev_ball_in, curr_ball_in;
    logic [2:0]  color_ball_in;
    logic [11:0] color_plats_in;
    logic [27:0] position_plats_in;
    logic        plot_ready;
    logic        busy, done, plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    always #5 clk = ~clk;

    frame_draw_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .prev_ball_in      (prev_ball_in),
        .curr_ball_in      (curr_ball_in),
        .color_ball_in     (color_ball_in),
        .color_plats_in    (color_plats_in),
        .position_plats_in (position_plats_in),
        .plot_ready        (plot_ready),
        .busy              (busy),
        .done              (done),
        .plot              (plot),
        .x                 (x),
        .y                 (y),
        .colour            (colour)
    );

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          exp_slots;
    int          n_checks = 0;
    int          n_pass   = 0;

    // ---------------- reference model ----------------
    task automatic add_rect(input int bx, input int by, input int w, input int h,
                            input logic [2:0] c);
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                exp_slots++;
                if ((bx + px) <= 159 && (by + py) <= 119)
                    exp_q.push_back({8'(bx + px), 7'(by + py), c});
            end
        end
    endtask

    task automatic push_expected();
        exp_q.delete();
        exp_slots = 0;
        if (prev_ball_in != curr_ball_in)
            add_rect(int'(prev_ball_in[7:4]) * 8, int'(prev_ball_in[3:0]) * 8, 8, 8, 3'b000);
        add_rect(int'(curr_ball_in[7:4]) * 8, int'(curr_ball_in[3:0]) * 8, 8, 8, color_ball_in);
        for (int i = 0; i < 4; i++)
            add_rect(i * 40, int'(position_plats_in[7*i +: 7]), 32, 2, color_plats_in[3*i +: 3]);
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size()) return i;
            if (got_q[i] !== exp_q[i]) return i;
        end
        if (got_q.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic set_default();
        prev_ball_in      = 8'h00;
        curr_ball_in      = 8'h11;
        color_ball_in     = 3'b111;
        color_plats_in    = 12'b001110111101;
        position_plats_in = 28'b0011110011110010110101100100;
        plot_ready        = 1'b1;
    endtask

    // Pulses start and records accepted pixels until done; cyc counts edges
    // from the edge that sampled start to the edge that raised done.
    task automatic run_frame(input bit rnd, input bit disturb, input int max_cyc,
                             output int cyc, output bit tmo);
        int k;
        got_q.delete();
        tmo = 1'b0;
        cyc = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (rnd) plot_ready = 1'($urandom_range(0, 1));
        k = 0;
        forever begin
            @(negedge clk);
            if (plot && plot_ready) got_q.push_back({x, y, colour});
            if (done) begin
                cyc = k;
                break;
            end
            if (k >= max_cyc) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk);
            k++;
            #1;
            if (rnd) plot_ready = 1'($urandom_range(0, 1));
            if (disturb) begin
                start = ((k % 50) == 7) || (k == 386);
                if ((k % 37) == 3) begin
                    prev_ball_in      = 8'($urandom);
                    curr_ball_in      = 8'($urandom);
                    color_ball_in     = 3'($urandom);
                    color_plats_in    = 12'($urandom);
                    position_plats_in = 28'($urandom);
                end
            end
        end
        if (disturb) begin
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        plot_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        set_default();
        repeat (3) @(negedge clk);
        n_checks++;
        if (plot !== 1'b0) $display("FAIL reset_plot: got %b want 0", plot); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++;
        if ({x, y, colour} !== 18'd0)
            $display("FAIL reset_xyc: got %h want 0", {x, y, colour});
        else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_default();
        int cyc; bit tmo; int d;
        set_default();
        push_expected();
        run_frame(1'b0, 1'b0, 2000, cyc, tmo);
        n_checks++;
        if (tmo) $display("FAIL default_timeout: got no done want done"); else n_pass++;
        n_checks++;
        if (got_q.size() !== 384) $display("FAIL default_count: got %0d want 384", got_q.size()); else n_pass++;
        n_checks++;
        if (got_q[0] !== {8'd0, 7'd0, 3'b000})
            $display("FAIL default_first: got %h want %h", got_q[0], {8'd0, 7'd0, 3'b000});
        else n_pass++;
        n_checks++;
        if (got_q[64] !== {8'd8, 7'd8, 3'b111})
            $display("FAIL default_ball_first: got %h want %h", got_q[64], {8'd8, 7'd8, 3'b111});
        else n_pass++;
        n_checks++;
        if (got_q[128] !== {8'd0, 7'd100, 3'b101})
            $display("FAIL default_plat0_first: got %h want %h", got_q[128], {8'd0, 7'd100, 3'b101});
        else n_pass++;
        n_checks++;
        if (got_q[320] !== {8'd120, 7'd30, 3'b001})
            $display("FAIL default_plat3_first: got %h want %h", got_q[320], {8'd120, 7'd30, 3'b001});
        else n_pass++;
        n_checks++;
        if (cyc !== 386) $display("FAIL default_latency: got %0d want 386", cyc); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL default_seq: got mismatch at %0d want none", d); else n_pass++;
    endtask

    task automatic test_skip_erase();
        int cyc; bit tmo; int d;
        set_default();
        prev_ball_in = 8'h11;
        push_expected();
        run_frame(1'b0, 1'b0, 2000, cyc, tmo);
        n_checks++;
        if (got_q.size() !== 320) $display("FAIL skip_count: got %0d want 320", got_q.size()); else n_pass++;
        n_checks++;
        if (got_q[0] !== {8'd8, 7'd8, 3'b111})
            $display("FAIL skip_first: got %h want %h", got_q[0], {8'd8, 7'd8, 3'b111});
        else n_pass++;
        n_checks++;
        if (cyc !== 322) $display("FAIL skip_latency: got %0d want 322", cyc); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL skip_seq: got mismatch at %0d want none", d); else n_pass++;
    endtask

    task automatic test_stall();
        int cyc; bit tmo; int d;
        set_default();
        push_expected();
        run_frame(1'b1, 1'b0, 5000, cyc, tmo);
        n_checks++;
        if (tmo) $display("FAIL stall_timeout: got no done want done"); else n_pass++;
        n_checks++;
        if (got_q.size() !== 384) $display("FAIL stall_count: got %0d want 384", got_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL stall_seq: got mismatch at %0d want none", d); else n_pass++;
    endtask

    task automatic test_clip();
        int cyc; bit tmo; int d; bit found; bit offscreen;
        set_default();
        position_plats_in[20:14] = 7'd119;
        push_expected();
        run_frame(1'b0, 1'b0, 2000, cyc, tmo);
        found = 1'b0;
        offscreen = 1'b0;
        foreach (got_q[i]) begin
            if (got_q[i] === {8'd80, 7'd119, 3'b110}) found = 1'b1;
            if (got_q[i][9:3] > 7'd119) offscreen = 1'b1;
        end
        n_checks++;
        if (got_q.size() !== 352) $display("FAIL clip_count: got %0d want 352", got_q.size()); else n_pass++;
        n_checks++;
        if (found !== 1'b1) $display("FAIL clip_row119: got %b want 1", found); else n_pass++;
        n_checks++;
        if (offscreen !== 1'b0) $display("FAIL clip_offscreen: got %b want 0", offscreen); else n_pass++;
        n_checks++;
        if (cyc !== 386) $display("FAIL clip_latency: got %0d want 386", cyc); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL clip_seq: got mismatch at %0d want none", d); else n_pass++;
    endtask

    task automatic test_disturb();
        int cyc; bit tmo; int d;
        set_default();
        push_expected();
        run_frame(1'b0, 1'b1, 2000, cyc, tmo);
        n_checks++;
        if (cyc !== 386) $display("FAIL disturb_latency: got %0d want 386", cyc); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL disturb_seq: got mismatch at %0d want none", d); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) $display("FAIL disturb_no_restart: got busy %b want 0", busy); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit tmo; int d;
        set_default();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({plot, colour} !== 4'b1111)
            $display("FAIL mid_in_ball: got plot/colour %b want 1111", {plot, colour});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, plot} !== 3'b000)
            $display("FAIL mid_reset_ctrl: got %b want 000", {busy, done, plot});
        else n_pass++;
        n_checks++;
        if ({x, y, colour} !== 18'd0)
            $display("FAIL mid_reset_xyc: got %h want 0", {x, y, colour});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_expected();
        run_frame(1'b0, 1'b0, 2000, cyc, tmo);
        n_checks++;
        if (cyc !== 386) $display("FAIL mid_after_latency: got %0d want 386", cyc); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d !== -1) $display("FAIL mid_after_seq: got mismatch at %0d want none", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default();
        test_skip_erase();
        test_stall();
        test_clip();
        test_disturb();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_draw_sequencer.md
Name: frame_draw_sequencer

Overview:
- Reader side of the game-state register block: consumes its stored ball, platform and colour fields and converts one snapshot into a stream of single-pixel writes for the VGA adapter.
- Once per frame: erases the previous ball, draws the current ball, then draws four platforms.
- Pixel interface has a valid/ready handshake so a slow framebuffer can stall it.
- Sits between the game-state register and the VGA adapter; the game controller pulses start once per frame tick.

Parameters:
- BALL_SZ, 8, ball square edge in pixels; ball cell pitch also BALL_SZ.
- PLAT_W, 32, platform width in pixels (max 63).
- PLAT_H, 2, platform height in pixels (max 7).
- PLAT_PITCH, 40, x spacing between platform slots; slot i starts at x = i*PLAT_PITCH.
- BG_COLOUR, 3'b000, colour used to erase the previous ball.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle request to draw one frame; sampled only in IDLE.
- prev_ball_in  input  8  previous ball position {col[3:0], row[3:0]}.
- curr_ball_in  input  8  current ball position, same format.
- color_ball_in  input  3  ball colour.
- color_plats_in  input  12  platform i colour = bits[3i+2:3i].
- position_plats_in  input  28  platform i top row y = bits[7i+6:7i].
- plot_ready  input  1  adapter accepts the presented pixel this cycle.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last pixel is accepted.
- plot  output  1  pixel valid.
- x  output  8  pixel x (0..159).
- y  output  7  pixel y (0..119).
- colour  output  3  pixel colour.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - state = IDLE; busy, done and plot = 0; x, y and colour = 0.
  - Snapshot registers cleared; any partially drawn frame is abandoned.
- All outputs are registered.
- States: IDLE -> LOAD -> ERASE -> BALL -> PLAT -> DONE -> IDLE.
- IDLE:
  - start=1 moves to LOAD and sets busy=1 on the same edge.
  - start is ignored in every other state, including DONE.
- LOAD, one cycle:
  - Captures all data inputs into the snapshot. Later input changes do not affect this frame.
  - Goes to ERASE if prev != curr, otherwise to BALL.
- ERASE: scans a BALL_SZ x BALL_SZ square.
  - x = prev.col*BALL_SZ + px; y = prev.row*BALL_SZ + py; colour = BG_COLOUR.
- BALL: same scan at curr with colour = snapshot ball colour.
- PLAT: platforms 0 to 3 in order, each scanning PLAT_W x PLAT_H.
  - x = i*PLAT_PITCH + px; y = pos_i + py; colour = colour_i.
- Scan order is row-major: px is the inner loop, py the outer loop.
- Handshake:
  - plot, x, y and colour are held stable while plot=1 and plot_ready=0.
  - A pixel completes on any edge where plot=1 and plot_ready=1; the next pixel is presented on the following cycle.
  - There are no bubbles between pixels when plot_ready is held high.
- Clipping:
  - Pixels with computed y > 119 or x > 159 are suppressed: plot=0 for that slot.
  - Suppressed slots advance in one cycle without waiting for plot_ready.
  - Arithmetic is carried one bit wider than x/y so clipping is compared before truncation.
- Latency with plot_ready tied high and default parameters:
  - The first plot is high two edges after start is sampled.
  - Pixel count is 64 (erase) + 64 (ball) + 4*64 (platforms) = 384, or 320 with the erase skipped.
  - DONE follows the last pixel: done=1 and busy=0 for one cycle, then IDLE.
  - Start-to-done is 1 + 384 + 1 cycles, or 1 + 320 + 1 cycles.

Decomposition:
- Package color_bounce_pkg holds:
  - state enum.
  - SCREEN_W=160 and SCREEN_H=120.
  - Field width constants: ball 8, position 7, colour 3, platform count 4.
  - Field-slice helper functions for platform i position and colour.
- Sub-module rect_scanner:
  - Inputs: load, advance, w, h.
  - Outputs: px, py, last.
  - Instantiated once and reused for every shape.

Test Plan:
- Default snapshot: prev=8'h00, curr=8'h11, colour 3'b111, colours 12'b001110111101, positions 28'b0011110011110010110101100100, plot_ready=1.
  - Required: 384 plots.
  - First: (0,0,000). First ball pixel: (8,8,111).
  - Platform 0 first pixel: (0,100,101). Platform 3 first pixel: (120,30,001).
  - done exactly 386 cycles after start.
- Same snapshot with prev=curr=8'h11 -> erase skipped; 320 plots; first plot (8,8,111).
- plot_ready toggled 1/0 randomly -> each pixel held until accepted; pixel sequence identical to the unstalled run; no pixel lost or duplicated.
- Platform 2 position 7'd119, PLAT_H=2 -> (80,119) plotted; the row-120 slots suppressed with plot=0; done still asserted.
- start pulsed while busy, and data inputs changed mid-frame -> no restart; drawn colours and positions match the LOAD-cycle snapshot.
- reset driven 0 during BALL -> outputs immediately 0 and state IDLE; after release, a new start produces a full, correct frame.
